hci_tcdm_bank_responder: RTL and testbench



---
 rtl/hci_tcdm_bank_responder_pkg.sv | 30 +++
 rtl/hci_tcdm_bank_responder_stall_gen.sv | 69 ++++++
 rtl/hci_tcdm_bank_responder.sv | 122 ++++++++++++
 tb/tb_hci_tcdm_bank_responder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hci_tcdm_bank_responder_pkg.sv
// -----------------------------------------------------------------------------
// hci_package
// Shared definitions for the TCDM bank responder and its stall generator:
//   - stall_state_e : two-state grant/stall FSM encoding
//   - hci_off_w()   : byte-offset width of a DW-bit word (low address bits)
//   - hci_cnt_w()   : width of the stall generator cycle counter
// -----------------------------------------------------------------------------
package hci_package;

    typedef enum logic [0:0] {
        STALL_GRANT = 1'b0,
        STALL_STALL = 1'b1
    } stall_state_e;

    // Number of byte-offset bits below the word index.
    function automatic int unsigned hci_off_w(input int unsigned dw);
        return $clog2(dw / 8);
    endfunction

    // Counter must reach max(period, len) - 1; never narrower than 1 bit.
    function automatic int unsigned hci_cnt_w(input int unsigned period,
                                              input int unsigned len);
        int unsigned mx;
        int unsigned w;
        mx = (period > len) ? period : len;
        w  = $clog2(mx);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/hci_tcdm_bank_responder_stall_gen.sv
// -----------------------------------------------------------------------------
// hci_stall_gen
// Periodic grant generator: STALL_PERIOD granted cycles followed by STALL_LEN
// stalled cycles, repeating. STALL_PERIOD = 0 keeps the grant permanently high.
// The counter runs every cycle regardless of traffic, so the pattern is a pure
// function of the cycle count since reset / clear.
// Ports:
//   clk_i    in  clock
//   rst_ni   in  asynchronous active-low reset
//   i_clear  in  synchronous return to GRANT with counter cleared
//   o_gnt    out grant (high in GRANT state)
// -----------------------------------------------------------------------------
module hci_stall_gen
    import hci_package::*;
#(
    parameter int unsigned STALL_PERIOD = 0,
    parameter int unsigned STALL_LEN    = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_clear,
    output logic o_gnt
);

    localparam int unsigned CW = hci_cnt_w(STALL_PERIOD, STALL_LEN);
    localparam logic [CW-1:0] PER_LAST = CW'((STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0);
    localparam logic [CW-1:0] LEN_LAST = CW'((STALL_LEN > 0) ? STALL_LEN - 1 : 0);

    stall_state_e  r_state;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= STALL_GRANT;
            r_cnt   <= '0;
        end else if (i_clear) begin
            r_state <= STALL_GRANT;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                STALL_GRANT: begin
                    // With STALL_PERIOD = 0 the exit is never taken; the
                    // counter just free-runs and wraps harmlessly.
                    if (STALL_PERIOD != 0 && r_cnt == PER_LAST) begin
                        r_state <= STALL_STALL;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                STALL_STALL: begin
                    if (r_cnt == LEN_LAST) begin
                        r_state <= STALL_GRANT;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= STALL_GRANT;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_gnt = (r_state == STALL_GRANT);

endmodule

// File: rtl/hci_tcdm_bank_responder.sv
// -----------------------------------------------------------------------------
// hci_tcdm_bank_responder
// One TCDM bank seen from an interconnect master port. Accepts one
// transaction per granted cycle and answers with r_valid exactly one cycle
// after the handshake. Grants can be throttled by a periodic stall pattern.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   clear_i             synchronous clear of control state (memory kept)
//   req_i, add_i        request valid, byte address (wraps modulo bank size)
//   wen_i               1 = read, 0 = write
//   be_i, data_i        write byte enables and data
//   gnt_o               grant, independent of req_i
//   r_data_o, r_valid_o response data (held between reads) and valid
//   n_reads_o/n_writes_o saturating counts of granted reads/writes
// -----------------------------------------------------------------------------
module hci_tcdm_bank_responder
    import hci_package::*;
#(
    parameter int unsigned DW            = 32,
    parameter int unsigned AW            = 32,
    parameter int unsigned NB_WORDS      = 256,
    parameter int unsigned STALL_PERIOD  = 0,
    parameter int unsigned STALL_LEN     = 1,
    parameter bit          WRITE_R_VALID = 1'b1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              req_i,
    input  logic [AW-1:0]     add_i,
    input  logic              wen_i,
    input  logic [DW/8-1:0]   be_i,
    input  logic [DW-1:0]     data_i,
    output logic              gnt_o,
    output logic [DW-1:0]     r_data_o,
    output logic              r_valid_o,
    output logic [CNT_W-1:0]  n_reads_o,
    output logic [CNT_W-1:0]  n_writes_o
);

    localparam int unsigned OFF_W  = hci_off_w(DW);
    localparam int unsigned IDX_W  = $clog2(NB_WORDS);
    localparam int unsigned NBYTES = DW / 8;
    localparam logic [AW-1:0]    IDX_MASK = AW'(NB_WORDS - 1) << OFF_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             w_gnt;
    logic             w_hs;
    logic [IDX_W-1:0] w_idx;
    logic             w_unused_addr;

    logic [DW-1:0]    r_mem [NB_WORDS];
    logic [DW-1:0]    r_r_data;
    logic             r_r_valid;
    logic [CNT_W-1:0] r_n_reads;
    logic [CNT_W-1:0] r_n_writes;

    hci_stall_gen #(
        .STALL_PERIOD (STALL_PERIOD),
        .STALL_LEN    (STALL_LEN)
    ) u_stall_gen (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_clear (clear_i),
        .o_gnt   (w_gnt)
    );

    // Byte-offset and above-bank address bits are deliberately dropped.
    assign w_idx         = add_i[OFF_W +: IDX_W];
    assign w_unused_addr = ^(add_i & ~IDX_MASK);

    // clear_i suppresses the transaction entirely, even though gnt_o is high.
    assign w_hs = req_i & w_gnt & ~clear_i;

    // Memory: zeroed by reset only; clear_i leaves contents alone.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int w = 0; w < NB_WORDS; w++) begin
                r_mem[w] <= '0;
            end
        end else if (w_hs && !wen_i) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (be_i[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= data_i[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_r_data   <= '0;
            r_r_valid  <= 1'b0;
            r_n_reads  <= '0;
            r_n_writes <= '0;
        end else if (clear_i) begin
            r_r_data   <= '0;
            r_r_valid  <= 1'b0;
            r_n_reads  <= '0;
            r_n_writes <= '0;
        end else begin
            r_r_valid <= w_hs & (wen_i | WRITE_R_VALID);
            if (w_hs && wen_i) begin
                r_r_data <= r_mem[w_idx];
                if (r_n_reads != CNT_MAX) begin
                    r_n_reads <= r_n_reads + CNT_W'(1);
                end
            end
            if (w_hs && !wen_i && r_n_writes != CNT_MAX) begin
                r_n_writes <= r_n_writes + CNT_W'(1);
            end
        end
    end

    assign gnt_o      = w_gnt;
    assign r_data_o   = r_r_data;
    assign r_valid_o  = r_r_valid;
    assign n_reads_o  = r_n_reads;
    assign n_writes_o = r_n_writes;

endmodule

// File: tb/tb_hci_tcdm_bank_responder.sv
// Three instances: A (defaults), B (stalls 3/2, no write responses), C (2-bit
// counters). Drivers push expected responses into per-instance queues; the
// monitors pop and compare whenever r_valid_o is seen.
module tb_hci_tcdm_bank_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          stamp;
        logic [31:0] data;
    } rsp_t;
    rsp_t qa[$];
    rsp_t qb[$];

    // ---------------- instance A ----------------
    logic a_rst_n = 1'b0, a_clear = 1'b0, a_req = 1'b0, a_wen = 1'b0;
    logic [31:0] a_add = '0, a_data = '0;
    logic [3:0]  a_be = '0;
    logic        a_gnt, a_r_valid;
    logic [31:0] a_r_data;
    logic [15:0] a_nr, a_nw;
    logic [31:0] a_last = '0;

    hci_tcdm_bank_responder u_a (
        .clk_i(clk), .rst_ni(a_rst_n), .clear_i(a_clear), .req_i(a_req),
        .add_i(a_add), .wen_i(a_wen), .be_i(a_be), .data_i(a_data),
        .gnt_o(a_gnt), .r_data_o(a_r_data), .r_valid_o(a_r_valid),
        .n_reads_o(a_nr), .n_writes_o(a_nw)
    );

    // ---------------- instance B ----------------
    logic b_rst_n = 1'b0, b_clear = 1'b0, b_req = 1'b0, b_wen = 1'b0;
    logic [31:0] b_add = '0, b_data = '0;
    logic [3:0]  b_be = '0;
    logic        b_gnt, b_r_valid;
    logic [31:0] b_r_data;
    logic [15:0] b_nr, b_nw;
    int          kb;

    hci_tcdm_bank_responder #(
        .STALL_PERIOD(3), .STALL_LEN(2), .WRITE_R_VALID(1'b0)
    ) u_b (
        .clk_i(clk), .rst_ni(b_rst_n), .clear_i(b_clear), .req_i(b_req),
        .add_i(b_add), .wen_i(b_wen), .be_i(b_be), .data_i(b_data),
        .gnt_o(b_gnt), .r_data_o(b_r_data), .r_valid_o(b_r_valid),
        .n_reads_o(b_nr), .n_writes_o(b_nw)
    );

    // Cycles since B left reset: grant on phases 0..2, stall on 3..4.
    always @(posedge clk or negedge b_rst_n) begin
        if (!b_rst_n) kb <= 0;
        else          kb <= kb + 1;
    end

    // ---------------- instance C ----------------
    logic c_rst_n = 1'b0, c_clear = 1'b0, c_req = 1'b0, c_wen = 1'b0;
    logic [31:0] c_add = '0, c_data = '0;
    logic [3:0]  c_be = '0;
    logic        c_gnt, c_r_valid;
    logic [31:0] c_r_data;
    logic [1:0]  c_nr, c_nw;

    hci_tcdm_bank_responder #(.CNT_W(2)) u_c (
        .clk_i(clk), .rst_ni(c_rst_n), .clear_i(c_clear), .req_i(c_req),
        .add_i(c_add), .wen_i(c_wen), .be_i(c_be), .data_i(c_data),
        .gnt_o(c_gnt), .r_data_o(c_r_data), .r_valid_o(c_r_valid),
        .n_reads_o(c_nr), .n_writes_o(c_nw)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitors ----------------
    initial begin
        rsp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (a_r_valid) begin
                if (qa.size() > 0 && qa[0].stamp == cyc) begin
                    e = qa.pop_front();
                    chk("a_rdata", a_r_data, e.data);
                end else begin
                    chk("a_unexpected_rvalid", a_r_valid, 0);
                end
            end else if (qa.size() > 0 && qa[0].stamp <= cyc) begin
                e = qa.pop_front();
                chk("a_missing_rvalid", a_r_valid, 1);
            end
        end
    end

    initial begin
        rsp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (b_r_valid) begin
                if (qb.size() > 0 && qb[0].stamp == cyc) begin
                    e = qb.pop_front();
                    chk("b_rdata", b_r_data, e.data);
                end else begin
                    chk("b_unexpected_rvalid", b_r_valid, 0);
                end
            end else if (qb.size() > 0 && qb[0].stamp <= cyc) begin
                e = qb.pop_front();
                chk("b_missing_rvalid", b_r_valid, 1);
            end
        end
    end

    // ---------------- drivers ----------------
    // Write responses carry the held data of the last read.
    task automatic op_a(input logic req, input logic wen, input logic clr,
                        input logic [31:0] add, input logic [3:0] be,
                        input logic [31:0] data, input logic [31:0] exp);
        rsp_t e;
        @(negedge clk);
        a_req = req; a_wen = wen; a_clear = clr;
        a_add = add; a_be = be; a_data = data;
        $display("A op req=%0b wen=%0b clr=%0b add=%h be=%h data=%h", req, wen, clr, add, be, data);
        if (clr) begin
            a_last = '0;
        end else if (req) begin
            if (wen) a_last = exp;
            e.stamp = cyc + 1;
            e.data  = a_last;
            qa.push_back(e);
        end
    endtask

    task automatic idle_a();
        @(negedge clk);
        a_req = 1'b0; a_clear = 1'b0;
    endtask

    // Holds the request until the modelled grant comes, checking gnt_o each cycle.
    task automatic op_b(input logic wen, input logic [31:0] add,
                        input logic [31:0] data, input logic [31:0] exp);
        rsp_t e;
        bit   done;
        bit   g;
        done = 0;
        for (int t = 0; t < 8 && !done; t++) begin
            @(negedge clk);
            b_req = 1'b1; b_wen = wen; b_add = add; b_be = 4'hF; b_data = data;
            g = ((kb % 5) < 3);
            chk("b_gnt", b_gnt, g);
            if (g) begin
                done = 1;
                $display("B op wen=%0b add=%h data=%h granted", wen, add, data);
                if (wen) begin
                    e.stamp = cyc + 1;
                    e.data  = exp;
                    qb.push_back(e);
                end
            end
        end
        if (!done) chk("b_grant_timeout", 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [9:0] pat;
        rsp_t       e;
        pat = 10'b0011100111;   // bit i = expected gnt in cycle i (1,1,1,0,0,1,1,1,0,0)

        repeat (3) @(negedge clk);
        a_rst_n = 1'b1;
        @(negedge clk);
        chk("a_rst_gnt", a_gnt, 1);
        chk("a_rst_rvalid", a_r_valid, 0);
        chk("a_rst_rdata", a_r_data, 0);
        chk("a_rst_nreads", a_nr, 0);
        chk("a_rst_nwrites", a_nw, 0);

        // full write then read
        op_a(1, 0, 0, 32'h10, 4'hF, 32'hDEADBEEF, 0);
        op_a(1, 1, 0, 32'h10, 4'h0, 0, 32'hDEADBEEF);
        idle_a();
        chk("a_nreads_1", a_nr, 1);
        chk("a_nwrites_1", a_nw, 1);

        // partial write, then address wrap
        op_a(1, 0, 0, 32'h10, 4'hF, 32'h11223344, 0);
        op_a(1, 0, 0, 32'h10, 4'b0101, 32'hAABBCCDD, 0);
        op_a(1, 1, 0, 32'h10, 4'h0, 0, 32'h11BB33DD);
        op_a(1, 0, 0, 32'h400, 4'hF, 32'h5, 0);
        op_a(1, 1, 0, 32'h0, 4'h0, 0, 32'h5);
        idle_a();
        chk("a_nreads_2", a_nr, 3);
        chk("a_nwrites_2", a_nw, 4);

        // five reads, then clear with a live request
        op_a(1, 1, 0, 32'h10, 4'h0, 0, 32'h11BB33DD);
        op_a(1, 1, 0, 32'h0,  4'h0, 0, 32'h5);
        op_a(1, 1, 0, 32'h10, 4'h0, 0, 32'h11BB33DD);
        op_a(1, 1, 0, 32'h0,  4'h0, 0, 32'h5);
        op_a(1, 1, 0, 32'h10, 4'h0, 0, 32'h11BB33DD);
        op_a(1, 1, 1, 32'h10, 4'h0, 0, 0);
        idle_a();
        chk("a_clear_nreads", a_nr, 0);
        chk("a_clear_nwrites", a_nw, 0);
        chk("a_clear_rdata", a_r_data, 0);
        op_a(1, 1, 0, 32'h0,  4'h0, 0, 32'h5);
        op_a(1, 1, 0, 32'h10, 4'h0, 0, 32'h11BB33DD);
        idle_a();
        chk("a_post_clear_nreads", a_nr, 2);
        chk("a_post_clear_nwrites", a_nw, 0);

        // B: stall pattern from reset with req held high
        @(negedge clk);
        b_rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            b_req = 1'b1; b_wen = 1'b1; b_add = 32'h0; b_be = 4'h0;
            chk("b_stall_gnt", b_gnt, pat[i]);
            $display("B stall cycle %0d gnt=%0b", i, b_gnt);
            if (pat[i]) begin
                e.stamp = cyc + 1;
                e.data  = 32'h0;
                qb.push_back(e);
            end
        end
        @(negedge clk);
        b_req = 1'b0;
        chk("b_nreads_stall", b_nr, 6);
        chk("b_nwrites_stall", b_nw, 0);

        // B: alternating write/read, responses for reads only
        for (int i = 0; i < 4; i++) begin
            op_b(0, 32'h8, 32'hA0 + i, 0);
            op_b(1, 32'h8, 0, 32'hA0 + i);
        end
        @(negedge clk);
        b_req = 1'b0;
        chk("b_nreads_alt", b_nr, 10);
        chk("b_nwrites_alt", b_nw, 4);

        // C: saturation of 2-bit counters
        @(negedge clk);
        c_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            c_req = 1'b1; c_wen = 1'b1; c_add = 32'h4;
            $display("C read %0d", i);
        end
        @(negedge clk);
        c_wen = 1'b0; c_be = 4'hF; c_data = 32'h77;
        @(negedge clk);
        c_req = 1'b0;
        chk("c_nreads_sat", c_nr, 3);
        chk("c_nwrites", c_nw, 1);

        // C: reset during a pending response drops r_valid at once
        @(negedge clk);
        c_req = 1'b1; c_wen = 1'b1;
        @(posedge clk);
        #1;
        chk("c_rvalid_before_rst", c_r_valid, 1);
        c_req = 1'b0;
        c_rst_n = 1'b0;
        #1;
        chk("c_rvalid_after_rst", c_r_valid, 0);
        chk("c_nreads_after_rst", c_nr, 0);
        chk("c_gnt_in_rst", c_gnt, 1);

        repeat (3) @(negedge clk);
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
